// File: rtl/dcache_assoc_pkg.sv
// dcache_assoc shared types
// FSM states, word widths and a width helper.
package dcache_assoc_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = WORD_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    REFILL,
    UPDATE,
    FLUSH_SCAN
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/dcache_assoc_if.sv
// dcache_assoc core + memory bus
// Cache is the slave of the core and the master of memory.
interface dcache_assoc_if
  import dcache_assoc_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic              i_ren;
  logic              i_wen;
  logic [ADDR_W-1:0] i_addr;
  logic [WORD_W-1:0] i_wdata;
  logic [STRB_W-1:0] i_wstrb;
  logic [WORD_W-1:0] o_rdata;
  logic              o_hit;
  logic              o_busy;
  logic              i_flush;
  logic              o_flush_done;
  logic              o_mem_req;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [WORD_W-1:0] o_mem_wdata;
  logic              i_mem_ack;
  logic [WORD_W-1:0] i_mem_rdata;

  modport slave (
    input  i_ren, i_wen, i_addr, i_wdata, i_wstrb,
    input  i_flush, i_mem_ack, i_mem_rdata,
    output o_rdata, o_hit, o_busy, o_flush_done,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_ren, i_wen, i_addr, i_wdata, i_wstrb,
    output i_flush, i_mem_ack, i_mem_rdata,
    input  o_rdata, o_hit, o_busy, o_flush_done,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/dcache_assoc_way.sv
// dcache_assoc single way
// Tag/valid/dirty/data storage with comb lookup.
module dcache_assoc_way
  import dcache_assoc_pkg::*;
#(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 24,
  localparam int IDX_W     = clog2(SETS),
  localparam int WRD_W     = clog2(LINE_WORDS)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [WRD_W-1:0]  rd_word,
  input  logic [TAG_W-1:0]  cmp_tag,
  output logic              hit,
  output logic              valid,
  output logic              dirty,
  output logic [TAG_W-1:0]  tag,
  output logic [WORD_W-1:0] rdata,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [WRD_W-1:0]  wb_word,
  output logic [WORD_W-1:0] wb_data,
  input  logic              core_we,
  input  logic [WORD_W-1:0] core_wdata,
  input  logic [STRB_W-1:0] core_strb,
  input  logic              fill_we,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [WRD_W-1:0]  fill_word,
  input  logic [WORD_W-1:0] fill_data,
  input  logic              upd_we,
  input  logic [TAG_W-1:0]  upd_tag,
  input  logic              inv_all
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [WORD_W-1:0] data_q [SETS*LINE_WORDS];

  assign valid   = valid_q[rd_idx];
  assign dirty   = dirty_q[rd_idx];
  assign tag     = tag_q[rd_idx];
  assign hit     = valid && (tag == cmp_tag);
  assign rdata   = data_q[{rd_idx, rd_word}];
  assign wb_data = data_q[{wb_idx, wb_word}];

  // line state: invalidate-all, line install, dirty on core write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (inv_all) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (upd_we) begin
        valid_q[fill_idx] <= 1'b1;
        dirty_q[fill_idx] <= 1'b0;
      end
      if (core_we) dirty_q[rd_idx] <= 1'b1;
    end
  end

  // tag and data storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (upd_we) tag_q[fill_idx] <= upd_tag;
    if (fill_we) data_q[{fill_idx, fill_word}] <= fill_data;
    if (core_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (core_strb[b])
          data_q[{rd_idx, rd_word}][8*b +: 8] <= core_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_assoc.sv
// dcache_assoc top
// Set-associative write-back cache: FSM, victim select, memory port.
module dcache_assoc
  import dcache_assoc_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
)(
  input  logic clk,
  input  logic rst,
  dcache_assoc_if.slave bus
);

  localparam int WRD_W = clog2(LINE_WORDS);
  localparam int OFF_W = WRD_W + 2;
  localparam int IDX_W = clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? clog2(WAYS) : 1;
  localparam logic [WRD_W-1:0] LAST = WRD_W'(LINE_WORDS - 1);

  state_t            state;
  logic [WRD_W-1:0]  beat;
  logic [IDX_W-1:0]  lat_idx;
  logic [TAG_W-1:0]  req_tag_q;
  logic [TAG_W-1:0]  wb_tag;
  logic [WAY_W-1:0]  vway;
  logic [IDX_W-1:0]  scan_idx;
  logic [WAY_W-1:0]  scan_way;
  logic              scan_end;
  logic              flushing;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              flush_done;
  logic [WAY_W-1:0]  rr [SETS];

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WRD_W-1:0]  req_word;
  logic [IDX_W-1:0]  rd_idx;
  logic              req;
  logic              any_hit;
  logic              hit;
  logic              core_we;
  logic              fill_we;
  logic              upd_we;
  logic              inv_all;
  logic [WAY_W-1:0]  victim;
  logic              vic_dirty;
  logic [WORD_W-1:0] hit_data;
  logic [IDX_W-1:0]  nxt_idx;
  logic [WAY_W-1:0]  nxt_way;
  logic              nxt_end;
  logic              unused_bits;

  logic [WAYS-1:0]   w_hit;
  logic [WAYS-1:0]   w_valid;
  logic [WAYS-1:0]   w_dirty;
  logic [TAG_W-1:0]  w_tag    [WAYS];
  logic [WORD_W-1:0] w_rdata  [WAYS];
  logic [WORD_W-1:0] w_wbdata [WAYS];

  function automatic logic [ADDR_W-1:0] line_addr(
    input logic [TAG_W-1:0] t,
    input logic [IDX_W-1:0] i,
    input logic [WRD_W-1:0] b
  );
    return {t, i, b, 2'b00};
  endfunction

  assign req_tag     = bus.i_addr[ADDR_W-1 -: TAG_W];
  assign req_idx     = bus.i_addr[OFF_W +: IDX_W];
  assign req_word    = bus.i_addr[2 +: WRD_W];
  assign unused_bits = ^bus.i_addr[1:0];

  assign req     = bus.i_ren | bus.i_wen;
  assign any_hit = |w_hit;
  assign hit     = (state == IDLE) && !bus.i_flush && req && any_hit;
  assign core_we = hit && bus.i_wen;
  assign fill_we = (state == REFILL) && mem_req && bus.i_mem_ack;
  assign upd_we  = (state == UPDATE);
  assign inv_all = (state == FLUSH_SCAN) && scan_end;

  assign rd_idx = (state == IDLE)       ? req_idx :
                  (state == FLUSH_SCAN) ? scan_idx : lat_idx;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_assoc_way #(
      .SETS(SETS),
      .LINE_WORDS(LINE_WORDS),
      .TAG_W(TAG_W)
    ) u_way (
      .clk(clk),
      .rst(rst),
      .rd_idx(rd_idx),
      .rd_word(req_word),
      .cmp_tag(req_tag),
      .hit(w_hit[w]),
      .valid(w_valid[w]),
      .dirty(w_dirty[w]),
      .tag(w_tag[w]),
      .rdata(w_rdata[w]),
      .wb_idx(lat_idx),
      .wb_word(beat),
      .wb_data(w_wbdata[w]),
      .core_we(core_we && w_hit[w]),
      .core_wdata(bus.i_wdata),
      .core_strb(bus.i_wstrb),
      .fill_we(fill_we && (vway == WAY_W'(w))),
      .fill_idx(lat_idx),
      .fill_word(beat),
      .fill_data(bus.i_mem_rdata),
      .upd_we(upd_we && (vway == WAY_W'(w))),
      .upd_tag(req_tag_q),
      .inv_all(inv_all)
    );
  end

  // hit word mux; at most one way matches
  always_comb begin
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_hit[w]) hit_data = hit_data | w_rdata[w];
    end
  end

  // victim: lowest invalid way, else the set's round-robin pointer
  always_comb begin
    victim = rr[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_valid[w]) victim = WAY_W'(w);
    end
    vic_dirty = w_valid[victim] && w_dirty[victim];
  end

  // flush walker: way-major inside each set
  always_comb begin
    nxt_way = scan_way + 1'b1;
    nxt_idx = scan_idx;
    nxt_end = 1'b0;
    if (scan_way == WAY_W'(WAYS - 1)) begin
      nxt_way = '0;
      if (scan_idx == IDX_W'(SETS - 1)) nxt_end = 1'b1;
      else nxt_idx = scan_idx + 1'b1;
    end
  end

  // round-robin pointer advances on every line install
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
    end else if (upd_we) begin
      rr[lat_idx] <= (rr[lat_idx] == WAY_W'(WAYS - 1)) ?
                     '0 : rr[lat_idx] + 1'b1;
    end
  end

  // main controller with registered memory-port outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      beat       <= '0;
      lat_idx    <= '0;
      req_tag_q  <= '0;
      wb_tag     <= '0;
      vway       <= '0;
      scan_idx   <= '0;
      scan_way   <= '0;
      scan_end   <= 1'b0;
      flushing   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_flush) begin
            state    <= FLUSH_SCAN;
            scan_idx <= '0;
            scan_way <= '0;
            scan_end <= 1'b0;
            flushing <= 1'b1;
          end else if (req && !any_hit) begin
            lat_idx   <= req_idx;
            req_tag_q <= req_tag;
            vway      <= victim;
            wb_tag    <= w_tag[victim];
            beat      <= '0;
            mem_req   <= 1'b1;
            if (vic_dirty) begin
              state    <= WB;
              mem_we   <= 1'b1;
              mem_addr <= line_addr(w_tag[victim], req_idx, '0);
            end else begin
              state    <= REFILL;
              mem_we   <= 1'b0;
              mem_addr <= line_addr(req_tag, req_idx, '0);
            end
          end
        end
        WB: begin
          if (bus.i_mem_ack) begin
            if (beat == LAST) begin
              beat <= '0;
              if (flushing) begin
                state    <= FLUSH_SCAN;
                mem_req  <= 1'b0;
                mem_we   <= 1'b0;
                scan_idx <= nxt_idx;
                scan_way <= nxt_way;
                scan_end <= nxt_end;
              end else begin
                state    <= REFILL;
                mem_we   <= 1'b0;
                mem_addr <= line_addr(req_tag_q, lat_idx, '0);
              end
            end else begin
              beat     <= beat + 1'b1;
              mem_addr <= line_addr(wb_tag, lat_idx, beat + 1'b1);
            end
          end
        end
        REFILL: begin
          if (bus.i_mem_ack) begin
            if (beat == LAST) begin
              state   <= UPDATE;
              beat    <= '0;
              mem_req <= 1'b0;
            end else begin
              beat     <= beat + 1'b1;
              mem_addr <= line_addr(req_tag_q, lat_idx, beat + 1'b1);
            end
          end
        end
        UPDATE: begin
          state <= IDLE;
        end
        FLUSH_SCAN: begin
          if (scan_end) begin
            state      <= IDLE;
            flushing   <= 1'b0;
            flush_done <= 1'b1;
          end else if (w_valid[scan_way] && w_dirty[scan_way]) begin
            state    <= WB;
            lat_idx  <= scan_idx;
            vway     <= scan_way;
            wb_tag   <= w_tag[scan_way];
            beat     <= '0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= line_addr(w_tag[scan_way], scan_idx, '0);
          end else begin
            scan_idx <= nxt_idx;
            scan_way <= nxt_way;
            scan_end <= nxt_end;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_hit        = hit;
  assign bus.o_rdata      = hit ? hit_data : '0;
  assign bus.o_busy       = (state != IDLE);
  assign bus.o_flush_done = flush_done;
  assign bus.o_mem_req    = mem_req;
  assign bus.o_mem_we     = mem_we;
  assign bus.o_mem_addr   = mem_addr;
  assign bus.o_mem_wdata  = (mem_req && mem_we) ? w_wbdata[vway] : '0;

endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc
// Directed scenarios against hand-computed expectations.
module tb_dcache_assoc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  logic [31:0] bt_addr  [16];
  logic        bt_we    [16];
  logic [31:0] bt_wdata [16];
  int          nb = 0;

  dcache_assoc_if #(.ADDR_W(32)) bus ();

  dcache_assoc #(
    .ADDR_W(32),
    .WAYS(2),
    .SETS(16),
    .LINE_WORDS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic mem_serve(input int n, input logic [31:0] d0);
    int got;
    int waitc;
    got = 0;
    waitc = 0;
    while (got < n && waitc < 60) begin
      @(negedge clk); #1;
      if (bus.o_mem_req) begin
        if (nb < 16) begin
          bt_addr[nb]  = bus.o_mem_addr;
          bt_we[nb]    = bus.o_mem_we;
          bt_wdata[nb] = bus.o_mem_wdata;
          nb++;
        end
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = d0 + 32'(got);
        got++;
      end else begin
        bus.i_mem_ack = 1'b0;
        waitc++;
      end
    end
    @(posedge clk); #1;
    bus.i_mem_ack = 1'b0;
    total++;
    if (got !== n) $display("FAIL beats_served got %0d want %0d", got, n);
    else passed++;
  endtask

  task automatic wait_hit();
    int n;
    n = 0;
    while (!bus.o_hit && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    bus.i_ren = 1'b1; bus.i_wen = 1'b0; bus.i_addr = 32'h100;
    bus.i_wdata = '0; bus.i_wstrb = '0; bus.i_flush = 1'b0;
    bus.i_mem_ack = 1'b0; bus.i_mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (bus.o_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.o_busy);
    else passed++;
    total++;
    if (bus.o_mem_req !== 1'b0) $display("FAIL rst_req got %b want 0", bus.o_mem_req);
    else passed++;
    total++;
    if (bus.o_hit !== 1'b0 || bus.o_rdata !== 32'h0)
      $display("FAIL rst_hit got %b/%h want 0/0", bus.o_hit, bus.o_rdata);
    else passed++;
    total++;
    if (bus.o_flush_done !== 1'b0 || bus.o_mem_addr !== 32'h0)
      $display("FAIL rst_outs got %b/%h want 0/0", bus.o_flush_done, bus.o_mem_addr);
    else passed++;
    bus.i_ren = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      total++;
      if (bus.o_busy !== 1'b0 || bus.o_mem_req !== 1'b0)
        $display("FAIL idle_quiet got %b/%b want 0/0", bus.o_busy, bus.o_mem_req);
      else passed++;
    end
  endtask

  task automatic test_cold_read();
    int t0;
    @(negedge clk);
    bus.i_ren = 1'b1; bus.i_addr = 32'h100;
    t0 = cyc;
    #1;
    total++;
    if (bus.o_hit !== 1'b0) $display("FAIL cold_miss got %b want 0", bus.o_hit);
    else passed++;
    nb = 0;
    mem_serve(4, 32'hA0);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (bt_addr[k] !== 32'h100 + 32'(4*k) || bt_we[k] !== 1'b0)
        $display("FAIL cold_beat%0d got %h/%b want %h/0", k, bt_addr[k], bt_we[k],
                 32'h100 + 32'(4*k));
      else passed++;
    end
    wait_hit();
    total++;
    if (bus.o_hit !== 1'b1 || bus.o_rdata !== 32'hA0)
      $display("FAIL cold_hit got %b/%h want 1/000000a0", bus.o_hit, bus.o_rdata);
    else passed++;
    total++;
    if (cyc - t0 !== 6) $display("FAIL cold_latency got %0d want 6", cyc - t0);
    else passed++;
    bus.i_ren = 1'b0;
  endtask

  task automatic test_write_hit();
    @(negedge clk);
    bus.i_wen = 1'b1; bus.i_addr = 32'h104;
    bus.i_wdata = 32'hFFFF1234; bus.i_wstrb = 4'b0011;
    #1;
    total++;
    if (bus.o_hit !== 1'b1) $display("FAIL wr_hit got %b want 1", bus.o_hit);
    else passed++;
    @(negedge clk);
    bus.i_wen = 1'b0; bus.i_ren = 1'b1;
    #1;
    total++;
    if (bus.o_hit !== 1'b1 || bus.o_rdata !== 32'h00001234)
      $display("FAIL wr_merge got %b/%h want 1/00001234", bus.o_hit, bus.o_rdata);
    else passed++;
    @(negedge clk);
    bus.i_addr = 32'h108;
    #1;
    total++;
    if (bus.o_rdata !== 32'hA2) $display("FAIL rd_108 got %h want 000000a2", bus.o_rdata);
    else passed++;
    bus.i_ren = 1'b0;
  endtask

  task automatic test_evict();
    logic [31:0] exp_wb [4];
    exp_wb[0] = 32'hA0; exp_wb[1] = 32'h00001234;
    exp_wb[2] = 32'hA2; exp_wb[3] = 32'hA3;
    @(negedge clk);
    bus.i_ren = 1'b1; bus.i_addr = 32'h200;
    nb = 0;
    mem_serve(4, 32'hB0);
    total++;
    if (bt_addr[0] !== 32'h200 || bt_we[0] !== 1'b0)
      $display("FAIL fill200 got %h/%b want 00000200/0", bt_addr[0], bt_we[0]);
    else passed++;
    wait_hit();
    total++;
    if (bus.o_rdata !== 32'hB0) $display("FAIL hit200 got %h want 000000b0", bus.o_rdata);
    else passed++;
    @(negedge clk);
    bus.i_addr = 32'h300;
    nb = 0;
    mem_serve(8, 32'hBC);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (bt_we[k] !== 1'b1 || bt_addr[k] !== 32'h100 + 32'(4*k) ||
          bt_wdata[k] !== exp_wb[k])
        $display("FAIL wb_beat%0d got %b/%h/%h want 1/%h/%h", k, bt_we[k], bt_addr[k],
                 bt_wdata[k], 32'h100 + 32'(4*k), exp_wb[k]);
      else passed++;
    end
    for (int k = 4; k < 8; k++) begin
      total++;
      if (bt_we[k] !== 1'b0 || bt_addr[k] !== 32'h300 + 32'(4*(k-4)))
        $display("FAIL rf_beat%0d got %b/%h want 0/%h", k, bt_we[k], bt_addr[k],
                 32'h300 + 32'(4*(k-4)));
      else passed++;
    end
    wait_hit();
    total++;
    if (bus.o_rdata !== 32'hC0) $display("FAIL hit300 got %h want 000000c0", bus.o_rdata);
    else passed++;
    @(negedge clk);
    bus.i_ren = 1'b0; bus.i_wen = 1'b1; bus.i_addr = 32'h308;
    bus.i_wdata = 32'hDEADBEEF; bus.i_wstrb = 4'hF;
    #1;
    total++;
    if (bus.o_hit !== 1'b1) $display("FAIL wr308 got %b want 1", bus.o_hit);
    else passed++;
    @(negedge clk);
    bus.i_wen = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'hD0; exp_d[1] = 32'hD1; exp_d[2] = 32'hD2; exp_d[3] = 32'hD3;
    @(negedge clk);
    bus.i_ren = 1'b1; bus.i_addr = 32'h400;
    nb = 0;
    mem_serve(2, 32'hD0);
    total++;
    if (bt_addr[0] !== 32'h400 || bt_we[0] !== 1'b0)
      $display("FAIL clean_victim got %h/%b want 00000400/0", bt_addr[0], bt_we[0]);
    else passed++;
    bus.i_mem_rdata = 32'hBAD0BAD0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      total++;
      if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 32'h408 || bus.o_mem_we !== 1'b0)
        $display("FAIL stall%0d got %b/%h/%b want 1/00000408/0", i, bus.o_mem_req,
                 bus.o_mem_addr, bus.o_mem_we);
      else passed++;
    end
    mem_serve(2, 32'hD2);
    wait_hit();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.i_addr = 32'h400 + 32'(4*k);
      #1;
      total++;
      if (bus.o_hit !== 1'b1 || bus.o_rdata !== exp_d[k])
        $display("FAIL stall_word%0d got %b/%h want 1/%h", k, bus.o_hit, bus.o_rdata,
                 exp_d[k]);
      else passed++;
    end
    bus.i_ren = 1'b0;
  endtask

  task automatic test_flush();
    int fdone;
    int hits;
    logic [31:0] exp_wb [4];
    exp_wb[0] = 32'hC0; exp_wb[1] = 32'hC1;
    exp_wb[2] = 32'hDEADBEEF; exp_wb[3] = 32'hC3;
    fdone = 0;
    hits = 0;
    nb = 0;
    @(negedge clk);
    bus.i_flush = 1'b1; bus.i_ren = 1'b1; bus.i_addr = 32'h400;
    #1;
    total++;
    if (bus.o_hit !== 1'b0) $display("FAIL flush_prio got %b want 0", bus.o_hit);
    else passed++;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      if (bus.o_hit) hits++;
      if (bus.o_flush_done) fdone++;
      if (bus.o_mem_req) begin
        if (nb < 16) begin
          bt_addr[nb] = bus.o_mem_addr;
          bt_we[nb] = bus.o_mem_we;
          bt_wdata[nb] = bus.o_mem_wdata;
        end
        nb++;
        bus.i_mem_ack = 1'b1;
      end else begin
        bus.i_mem_ack = 1'b0;
      end
      if (!bus.o_busy) begin
        bus.i_flush = 1'b0;
        bus.i_addr = 32'h200;
        break;
      end
    end
    total++;
    if (nb !== 4) $display("FAIL flush_beats got %0d want 4", nb);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (bt_we[k] !== 1'b1 || bt_addr[k] !== 32'h300 + 32'(4*k) ||
          bt_wdata[k] !== exp_wb[k])
        $display("FAIL flush_wb%0d got %b/%h/%h want 1/%h/%h", k, bt_we[k], bt_addr[k],
                 bt_wdata[k], 32'h300 + 32'(4*k), exp_wb[k]);
      else passed++;
    end
    total++;
    if (fdone !== 1) $display("FAIL flush_done got %0d want 1", fdone);
    else passed++;
    total++;
    if (hits !== 0) $display("FAIL flush_hits got %0d want 0", hits);
    else passed++;
    #1;
    total++;
    if (bus.o_hit !== 1'b0) $display("FAIL post_flush_hit got %b want 0", bus.o_hit);
    else passed++;
    @(negedge clk); #1;
    total++;
    if (bus.o_flush_done !== 1'b0 || bus.o_mem_req !== 1'b1 ||
        bus.o_mem_addr !== 32'h200 || bus.o_mem_we !== 1'b0)
      $display("FAIL post_flush_miss got %b/%b/%h/%b want 0/1/00000200/0",
               bus.o_flush_done, bus.o_mem_req, bus.o_mem_addr, bus.o_mem_we);
    else passed++;
    nb = 0;
    mem_serve(4, 32'hE0);
    wait_hit();
    total++;
    if (bus.o_rdata !== 32'hE0) $display("FAIL refill200 got %h want 000000e0", bus.o_rdata);
    else passed++;
    bus.i_ren = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.i_ren = 1'b1; bus.i_addr = 32'h100;
    nb = 0;
    mem_serve(2, 32'hF0);
    total++;
    if (bt_addr[0] !== 32'h100 || bt_we[0] !== 1'b0)
      $display("FAIL mid_first got %h/%b want 00000100/0", bt_addr[0], bt_we[0]);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (bus.o_mem_req !== 1'b0 || bus.o_busy !== 1'b0)
      $display("FAIL mid_rst got %b/%b want 0/0", bus.o_mem_req, bus.o_busy);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (bus.o_hit !== 1'b0) $display("FAIL after_rst_hit got %b want 0", bus.o_hit);
    else passed++;
    @(negedge clk); #1;
    total++;
    if (bus.o_busy !== 1'b1 || bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 32'h100)
      $display("FAIL after_rst_miss got %b/%b/%h want 1/1/00000100", bus.o_busy,
               bus.o_mem_req, bus.o_mem_addr);
    else passed++;
    nb = 0;
    mem_serve(4, 32'h70);
    wait_hit();
    total++;
    if (bus.o_hit !== 1'b1 || bus.o_rdata !== 32'h70)
      $display("FAIL after_rst_data got %b/%h want 1/00000070", bus.o_hit, bus.o_rdata);
    else passed++;
    bus.i_ren = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_hit();
    test_evict();
    test_stall();
    test_flush();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
